duc_dac_fmt: RTL and testbench

- Downstream neighbour of the quadrature DUC CORDIC stage.
- Captures each rotated I/Q pair (Q3.11, 14-bit) qualified by the DUC done strobe, applies digital output gain, then rounds and saturates to DAC width.
- Buffers pairs in a small FIFO and delivers an interleaved I/Q word stream to the DAC interface on demand.
- Absorbs rate jitter between DUC completion and DAC pull; flags underflow and overflow.

---
 rtl/duc_dac_pkg.sv | 47 ++++
 rtl/duc_dac_fifo.sv | 87 ++++++++
 rtl/duc_dac_fmt.sv | 198 +++++++++++++++++++
 tb/tb_duc_dac_fmt.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/duc_dac_pkg.sv
// Shared definitions for the DUC-to-DAC formatter: sample widths, the
// output state encoding and the round-half-up / saturate helper.
package duc_dac_pkg;

  localparam int DUC_IN_W  = 14;
  localparam int DUC_FRAC  = 11;
  localparam int GAIN_W    = 10;
  localparam int GAIN_FRAC = 8;
  localparam int PROD_W    = DUC_IN_W + GAIN_W;
  localparam int PROD_FRAC = DUC_FRAC + GAIN_FRAC;
  localparam int SUM_W     = PROD_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    UFLOW = 2'd3
  } dac_state_e;

  // Q5.19 product -> round-half-up to dac_w bits, clipped to the signed range.
  // One guard bit keeps the rounding add from wrapping at full scale.
  function automatic logic signed [PROD_W-1:0] round_sat(
    input logic signed [PROD_W-1:0] prod,
    input int                       dac_w
  );
    logic signed [SUM_W-1:0] sum_v;
    logic signed [SUM_W-1:0] rnd_v;
    logic signed [SUM_W-1:0] max_v;
    logic signed [SUM_W-1:0] min_v;
    logic signed [SUM_W-1:0] res_v;
    int                      shift_v;
    shift_v = PROD_FRAC - (dac_w - 1);
    sum_v   = $signed({prod[PROD_W-1], prod}) + $signed(SUM_W'(64'sd1 <<< (shift_v - 1)));
    rnd_v   = sum_v >>> shift_v;
    max_v   = $signed(SUM_W'((64'sd1 <<< (dac_w - 1)) - 64'sd1));
    min_v   = ~max_v;
    if (rnd_v > max_v) begin
      res_v = max_v;
    end else if (rnd_v < min_v) begin
      res_v = min_v;
    end else begin
      res_v = rnd_v;
    end
    return res_v[PROD_W-1:0];
  endfunction

endpackage

// File: rtl/duc_dac_fifo.sv
// Synchronous pair FIFO with flush; writes while full are dropped and the
// head entry is presented combinationally on o_rdata.
module duc_dac_fifo
  import duc_dac_pkg::*;
#(
  parameter int W     = 24,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok_s;
  logic          pop_ok_s;

  // Pointer and occupancy update.
  always_comb begin
    push_ok_s = i_push && (cnt_q != FULL_CNT) && !i_flush;
    pop_ok_s  = i_pop && (cnt_q != {CW{1'b0}}) && !i_flush;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    if (i_flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      cnt_d    = {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[rd_ptr_q];
  assign o_full  = (cnt_q == FULL_CNT);
  assign o_empty = (cnt_q == {CW{1'b0}});
  assign o_level = cnt_q;

endmodule

// File: rtl/duc_dac_fmt.sv
// DUC -> DAC formatter: gain, round/saturate, pair FIFO, interleaved I/Q output.
// Define DUC_DAC_OFFSET_BIN_EN for offset-binary output words.
module duc_dac_fmt
  import duc_dac_pkg::*;
#(
  parameter int DAC_W      = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int PRIME_LVL  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_en,
  input  logic [13:0]                   i_x,
  input  logic [13:0]                   i_y,
  input  logic                          i_done,
  input  logic [9:0]                    i_gain,
  input  logic                          i_clr,
  input  logic                          i_dac_req,
  output logic [DAC_W-1:0]              o_dac_data,
  output logic                          o_dac_iq,
  output logic                          o_dac_vld,
  output logic                          o_uflow,
  output logic                          o_ovf,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

`ifdef DUC_DAC_OFFSET_BIN_EN
  localparam logic [DAC_W-1:0] MSB_FLIP = {1'b1, {(DAC_W-1){1'b0}}};
`else
  localparam logic [DAC_W-1:0] MSB_FLIP = {DAC_W{1'b0}};
`endif
  localparam logic [DAC_W-1:0] ZERO_WORD = MSB_FLIP;

  logic signed [PROD_W-1:0] prod_x_q, prod_x_d;
  logic signed [PROD_W-1:0] prod_y_q, prod_y_d;
  logic                     s1_vld_q, s1_vld_d;
  dac_state_e               state_q, state_d;
  logic                     phase_q, phase_d;
  logic [DAC_W-1:0]         dac_data_q, dac_data_d;
  logic                     dac_iq_q, dac_iq_d;
  logic                     dac_vld_q, dac_vld_d;
  logic                     uflow_q, uflow_d;
  logic                     ovf_q, ovf_d;

  logic [2*DAC_W-1:0]       wr_pair_s;
  logic [2*DAC_W-1:0]       head_s;
  logic                     push_s, pop_s, full_s, empty_s;
  logic [LVL_W-1:0]         level_s;
  logic                     go_run_s, run_now_s;
  logic                     uflow_set_s, ovf_set_s;

  // Stage 1: gain multiply; gain is captured alongside its own sample.
  always_comb begin
    prod_x_d = $signed({{(PROD_W-DUC_IN_W){i_x[DUC_IN_W-1]}}, i_x})
             * $signed({{(PROD_W-GAIN_W){1'b0}}, i_gain});
    prod_y_d = $signed({{(PROD_W-DUC_IN_W){i_y[DUC_IN_W-1]}}, i_y})
             * $signed({{(PROD_W-GAIN_W){1'b0}}, i_gain});
    s1_vld_d = i_done & i_en;
  end

  // Stage 2: round/saturate feeds the FIFO write directly.
  always_comb begin
    wr_pair_s = {DAC_W'(round_sat(prod_x_q, DAC_W)), DAC_W'(round_sat(prod_y_q, DAC_W))};
    push_s    = s1_vld_q & i_en;
    ovf_set_s = push_s & full_s;
    go_run_s  = (level_s >= LVL_W'(PRIME_LVL)) && !phase_q;
  end

  duc_dac_fifo #(
    .W     (2*DAC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_flush (~i_en),
    .i_push  (push_s),
    .i_pop   (pop_s),
    .i_wdata (wr_pair_s),
    .o_rdata (head_s),
    .o_full  (full_s),
    .o_empty (empty_s),
    .o_level (level_s)
  );

  // Output sequencing; a primed FIFO serves the same-cycle request so the
  // stream always resumes on an I word.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    dac_data_d  = dac_data_q;
    dac_iq_d    = dac_iq_q;
    dac_vld_d   = 1'b0;
    pop_s       = 1'b0;
    uflow_set_s = 1'b0;
    run_now_s   = 1'b0;
    if (!i_en) begin
      state_d    = IDLE;
      phase_d    = 1'b0;
      dac_data_d = ZERO_WORD;
      dac_iq_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = PRIME;
          dac_data_d = ZERO_WORD;
          dac_iq_d   = 1'b0;
        end
        PRIME, UFLOW: begin
          if (go_run_s) begin
            state_d   = RUN;
            run_now_s = 1'b1;
          end else begin
            state_d   = state_q;
          end
        end
        RUN:     run_now_s = 1'b1;
        default: state_d = IDLE;
      endcase
      if (i_dac_req && (state_q != IDLE)) begin
        dac_vld_d = 1'b1;
        phase_d   = ~phase_q;
        if (run_now_s && !phase_q && empty_s) begin
          state_d     = UFLOW;
          uflow_set_s = 1'b1;
          dac_data_d  = ZERO_WORD;
          dac_iq_d    = 1'b0;
        end else if (run_now_s && !phase_q) begin
          dac_data_d = head_s[2*DAC_W-1:DAC_W] ^ MSB_FLIP;
          dac_iq_d   = 1'b0;
        end else if (run_now_s) begin
          dac_data_d = head_s[DAC_W-1:0] ^ MSB_FLIP;
          dac_iq_d   = 1'b1;
          pop_s      = 1'b1;
        end else begin
          dac_data_d = ZERO_WORD;
          dac_iq_d   = phase_q;
        end
      end else begin
        dac_vld_d = 1'b0;
      end
    end
  end

  // Sticky flags: a set event beats a clear in the same cycle.
  always_comb begin
    if (uflow_set_s) begin
      uflow_d = 1'b1;
    end else if (i_clr) begin
      uflow_d = 1'b0;
    end else begin
      uflow_d = uflow_q;
    end
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (i_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Pipeline, FSM and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_x_q   <= {PROD_W{1'b0}};
      prod_y_q   <= {PROD_W{1'b0}};
      s1_vld_q   <= 1'b0;
      state_q    <= IDLE;
      phase_q    <= 1'b0;
      dac_data_q <= {DAC_W{1'b0}};
      dac_iq_q   <= 1'b0;
      dac_vld_q  <= 1'b0;
      uflow_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      prod_x_q   <= prod_x_d;
      prod_y_q   <= prod_y_d;
      s1_vld_q   <= s1_vld_d;
      state_q    <= state_d;
      phase_q    <= phase_d;
      dac_data_q <= dac_data_d;
      dac_iq_q   <= dac_iq_d;
      dac_vld_q  <= dac_vld_d;
      uflow_q    <= uflow_d;
      ovf_q      <= ovf_d;
    end
  end

  assign o_dac_data = dac_data_q;
  assign o_dac_iq   = dac_iq_q;
  assign o_dac_vld  = dac_vld_q;
  assign o_uflow    = uflow_q;
  assign o_ovf      = ovf_q;
  assign o_level    = level_s;

endmodule

// File: tb/tb_duc_dac_fmt.sv
// Directed + randomized bench for duc_dac_fmt against a queue-based
// behavioural model of the gain/round/FIFO/stream rules (default build).
module tb_duc_dac_fmt;

  localparam int DAC_W = 12;
  localparam int DEPTH = 8;
  localparam int PLVL  = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_en, i_done, i_clr, i_dac_req;
  logic [13:0] i_x, i_y;
  logic [9:0]  i_gain;
  logic [11:0] o_dac_data;
  logic        o_dac_iq, o_dac_vld, o_uflow, o_ovf;
  logic [3:0]  o_level;

  always #5 clk = ~clk;

  duc_dac_fmt #(.DAC_W(DAC_W), .FIFO_DEPTH(DEPTH), .PRIME_LVL(PLVL)) dut (
    .clk(clk), .reset_n(reset_n), .i_en(i_en), .i_x(i_x), .i_y(i_y),
    .i_done(i_done), .i_gain(i_gain), .i_clr(i_clr), .i_dac_req(i_dac_req),
    .o_dac_data(o_dac_data), .o_dac_iq(o_dac_iq), .o_dac_vld(o_dac_vld),
    .o_uflow(o_uflow), .o_ovf(o_ovf), .o_level(o_level)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: queued pairs {I,Q}, streaming flag, IQ phase.
  logic [23:0] mq[$];
  bit          m_idle = 1'b1, m_stream = 1'b0, m_phase = 1'b0;
  bit          m_vld = 1'b0, m_iq = 1'b0, m_uflow = 1'b0, m_ovf = 1'b0, m_pend = 1'b0;
  logic [11:0] m_data = 12'd0;
  logic [23:0] m_pend_pair = 24'd0;

  // Real-valued gain, round-half-up, clip to the 12-bit range.
  function automatic logic [11:0] conv(input logic [13:0] s, input logic [9:0] g);
    int  xi;
    int  r;
    real v;
    xi = $signed(s);
    v  = $floor(real'(xi * int'(g)) / 256.0 + 0.5);
    r  = $rtoi(v);
    if (r > 2047) r = 2047;
    else if (r < -2048) r = -2048;
    return r[11:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit          full, pop, uflow_set, ovf_set;
    logic [23:0] head;
    pop = 1'b0; uflow_set = 1'b0; ovf_set = 1'b0;
    if (!i_en) begin
      mq.delete();
      m_idle = 1'b1; m_stream = 1'b0; m_phase = 1'b0;
      m_vld = 1'b0; m_data = 12'd0; m_iq = 1'b0; m_pend = 1'b0;
    end else begin
      full = (mq.size() == DEPTH);
      if (m_idle) begin
        m_idle = 1'b0; m_vld = 1'b0; m_data = 12'd0; m_iq = 1'b0;
      end else begin
        if (!m_stream && mq.size() >= PLVL && !m_phase) m_stream = 1'b1;
        m_vld = i_dac_req;
        if (i_dac_req) begin
          if (m_stream && !m_phase) begin
            if (mq.size() == 0) begin
              m_stream = 1'b0; uflow_set = 1'b1; m_data = 12'd0; m_iq = 1'b0;
            end else begin
              head = mq[0]; m_data = head[23:12]; m_iq = 1'b0;
            end
          end else if (m_stream) begin
            head = mq[0]; m_data = head[11:0]; m_iq = 1'b1; pop = 1'b1;
          end else begin
            m_data = 12'd0; m_iq = m_phase;
          end
          m_phase = !m_phase;
        end
      end
      if (pop) void'(mq.pop_front());
      if (m_pend) begin
        if (full) ovf_set = 1'b1;
        else mq.push_back(m_pend_pair);
      end
      m_pend      = i_done;
      m_pend_pair = {conv(i_x, i_gain), conv(i_y, i_gain)};
    end
    m_ovf   = ovf_set   ? 1'b1 : (i_clr ? 1'b0 : m_ovf);
    m_uflow = uflow_set ? 1'b1 : (i_clr ? 1'b0 : m_uflow);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("vld",   o_dac_vld,  m_vld);
    check("data",  o_dac_data, m_data);
    check("iq",    o_dac_iq,   m_iq);
    check("uflow", o_uflow,    m_uflow);
    check("ovf",   o_ovf,      m_ovf);
    check("level", o_level,    mq.size());
  endtask

  task automatic rnd_pair();
    i_x = 14'($urandom);
    i_y = 14'($urandom);
  endtask

  initial begin
    reset_n = 1'b0; i_en = 1'b0; i_done = 1'b0; i_clr = 1'b0; i_dac_req = 1'b0;
    i_x = 14'd0; i_y = 14'd0; i_gain = 10'd256;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  o_dac_data, 12'd0);
    check("rst_vld",   o_dac_vld,  1'b0);
    check("rst_iq",    o_dac_iq,   1'b0);
    check("rst_flags", {o_uflow, o_ovf}, 2'b00);
    check("rst_level", o_level,    4'd0);
    reset_n = 1'b1;
    cyc(); cyc();

    // Directed pairs: nominal, saturation, rounding at half gain.
    i_en = 1'b1; i_gain = 10'd256; i_done = 1'b1;
    i_x = 14'h0400; i_y = 14'h3C00; cyc();
    check("lat1", o_level, 4'd0);
    i_x = 14'h1000; i_y = 14'h3000; cyc();
    check("lat2", o_level, 4'd1);
    i_gain = 10'd128; i_x = 14'h0001; i_y = 14'h3FFF; cyc();
    i_gain = 10'd256; rnd_pair(); cyc();
    i_done = 1'b0; cyc();
    check("primed", o_level, 4'd4);

    i_dac_req = 1'b1;
    cyc(); check("w_i05",  o_dac_data, 12'd1024); check("w_i05_iq", o_dac_iq, 1'b0);
    cyc(); check("w_qm05", o_dac_data, 12'hC00);  check("w_qm05_iq", o_dac_iq, 1'b1);
    cyc(); check("w_satp", o_dac_data, 12'd2047);
    cyc(); check("w_satn", o_dac_data, 12'h800);
    cyc(); check("w_rnd1", o_dac_data, 12'd1);
    cyc(); check("w_rnd0", o_dac_data, 12'd0);
    cyc(); cyc();
    cyc(); check("uf_vld", o_dac_vld, 1'b1); check("uf_flag", o_uflow, 1'b1);
    check("uf_zero", o_dac_data, 12'd0);
    repeat (3) cyc();
    i_dac_req = 1'b0;

    // Refill after underflow; stream must resume on an I word.
    i_done = 1'b1;
    repeat (4) begin i_gain = 10'($urandom_range(0, 1023)); rnd_pair(); cyc(); end
    i_done = 1'b0; cyc(); cyc();
    i_dac_req = 1'b1; cyc();
    check("resume_iq", o_dac_iq, 1'b0); check("resume_vld", o_dac_vld, 1'b1);
    repeat (7) cyc();
    i_dac_req = 1'b0;

    // Overflow: nine back-to-back pairs into an empty eight-entry FIFO.
    i_en = 1'b0; cyc(); i_en = 1'b1; cyc();
    i_done = 1'b1;
    repeat (9) begin i_gain = 10'd256; rnd_pair(); cyc(); end
    i_done = 1'b0; cyc(); cyc();
    check("ovf_level", o_level, 4'd8); check("ovf_flag", o_ovf, 1'b1);
    i_dac_req = 1'b1; repeat (16) cyc(); i_dac_req = 1'b0;
    i_clr = 1'b1; cyc(); i_clr = 1'b0;
    check("clr_ovf", o_ovf, 1'b0); check("clr_uflow", o_uflow, 1'b0);

    // Set beats clear: refill to full, then clear on the overflowing write.
    i_done = 1'b1; repeat (8) begin rnd_pair(); cyc(); end
    i_done = 1'b0; cyc(); cyc();
    i_done = 1'b1; rnd_pair(); cyc();
    i_done = 1'b0; i_clr = 1'b1; cyc(); i_clr = 1'b0;
    check("set_wins", o_ovf, 1'b1);

    // Drop enable after an I word.
    i_dac_req = 1'b1; cyc(); check("pre_drop_iq", o_dac_iq, 1'b0);
    i_en = 1'b0; cyc();
    check("drop_vld", o_dac_vld, 1'b0); check("drop_level", o_level, 4'd0);
    i_en = 1'b1; i_dac_req = 1'b0; cyc();
    i_dac_req = 1'b1; cyc();
    check("reprime_vld", o_dac_vld, 1'b1); check("reprime_iq", o_dac_iq, 1'b0);
    check("reprime_zero", o_dac_data, 12'd0);
    i_dac_req = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      i_en      = ($urandom_range(0, 39) != 0);
      i_done    = ($urandom_range(0, 9) < 4);
      i_dac_req = ($urandom_range(0, 1) == 1);
      i_clr     = ($urandom_range(0, 29) == 0);
      i_gain    = ($urandom_range(0, 1) == 1) ? 10'd256 : 10'($urandom_range(0, 1023));
      rnd_pair();
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
